// File: rtl/nibble_serial_subtractor.sv
`default_nettype none
// ============================================================================
// nibble_serial_subtractor : a - b - borrow_in, one nibble per clock, LSB first
// Revision: 1.0
// ============================================================================
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero
);

    localparam int c_nibbles = WIDTH / 4;
    localparam int c_idx_w   = (c_nibbles > 1) ? $clog2(c_nibbles) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_nibbles - 1);
    localparam logic [WIDTH-1:0]   c_nib_mask = WIDTH'(4'hF);

    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_run  = 1'b1;

    logic [0:0]         r_state;
    logic [c_idx_w-1:0] r_idx;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_borrow;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow_out;
    logic               r_zero;
    logic               r_busy;
    logic               r_done;

    logic [c_idx_w+1:0] w_sh;
    logic [3:0]         w_a_nib;
    logic [3:0]         w_b_nib;
    logic [4:0]         w_t;
    logic [WIDTH-1:0]   w_diff_next;

    // Bit offset of the current nibble; the 5-bit difference's MSB is the borrow.
    always_comb begin
        w_sh        = {r_idx, 2'b00};
        w_a_nib     = 4'(r_a >> w_sh);
        w_b_nib     = 4'(r_b >> w_sh);
        w_t         = {1'b0, w_a_nib} - {1'b0, w_b_nib} - {4'b0000, r_borrow};
        w_diff_next = (r_diff & ~(c_nib_mask << w_sh)) | (WIDTH'(w_t[3:0]) << w_sh);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_idle;
            r_idx        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_borrow     <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_zero       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= borrow_in;
                        r_idx    <= '0;
                        r_diff   <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= c_run;
                    end
                end
                c_run: begin
                    r_diff   <= w_diff_next;
                    r_borrow <= w_t[4];
                    if (r_idx == c_last_idx) begin
                        r_borrow_out <= w_t[4];
                        r_zero       <= (w_diff_next == '0);
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= c_idle;
                    end else begin
                        r_idx <= r_idx + c_idx_w'(1);
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;
    assign zero       = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_subtractor.sv
`default_nettype none
// ============================================================================
// tb_nibble_serial_subtractor : scoreboard bench for the nibble subtractor
// Revision: 1.0
// ============================================================================
module tb_nibble_serial_subtractor;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             zero;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             bo;
        logic             z;
    } exp_t;

    exp_t exp_q[$];
    logic prev_done = 1'b0;

    nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .zero       (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse, plus handshake invariants.
    always @(negedge clk) begin
        if (done) begin
            check("busy_with_done", {31'b0, busy}, 32'd0);
            check("done_twice", {31'b0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("diff", {16'b0, diff}, {16'b0, e.diff});
                check("borrow_out", {31'b0, borrow_out}, {31'b0, e.bo});
                check("zero", {31'b0, zero}, {31'b0, e.z});
            end
        end
        prev_done = done;
    end

    task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic ibin);
        start     = 1'b1;
        a         = ia;
        b         = ib;
        borrow_in = ibin;
    endtask

    // Issues one operation and waits for its done; returns at the done cycle.
    task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                          input logic ibin, input logic [WIDTH-1:0] ediff,
                          input logic ebo, input logic ez);
        int busy_cnt;
        logic got;
        @(negedge clk);
        issue(ia, ib, ibin);
        exp_q.push_back('{diff: ediff, bo: ebo, z: ez});
        @(negedge clk);
        start    = 1'b0;
        busy_cnt = 0;
        got      = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (done) got = 1'b1;
            else begin
                if (busy) busy_cnt++;
                @(negedge clk);
            end
        end
        check("done_seen", {31'b0, got}, 32'd1);
        check("busy_cycles", busy_cnt, WIDTH / 4);
    endtask

    initial begin
        logic [WIDTH-1:0] ripple [4];
        int               wait_cnt;
        ripple = '{16'h000F, 16'h00FF, 16'h0FFF, 16'h7FFF};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_diff", {16'b0, diff}, 32'd0);
        check("reset_bo", {31'b0, borrow_out}, 32'd0);
        check("reset_zero", {31'b0, zero}, 32'd0);

        run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run_op(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_op(16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b1);

        // Borrow ripple: partial diff visible nibble by nibble after E1..E4.
        @(negedge clk);
        issue(16'h8000, 16'h0001, 1'b0);
        exp_q.push_back('{diff: 16'h7FFF, bo: 1'b0, z: 1'b0});
        @(negedge clk);
        start = 1'b0;
        check("diff_cleared_on_accept", {16'b0, diff}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("ripple_nibble", {16'b0, diff}, {16'b0, ripple[k]});
        end
        check("ripple_done_at_E4", {31'b0, done}, 32'd1);

        // Second start at E2 must be ignored; then restart in the done cycle.
        @(negedge clk);
        issue(16'h00FF, 16'h000F, 1'b0);
        exp_q.push_back('{diff: 16'h00F0, bo: 1'b0, z: 1'b0});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        issue(16'hAAAA, 16'h1111, 1'b1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("ignored_busy_E3", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check("ignored_done_E4", {31'b0, done}, 32'd1);
        issue(16'h1234, 16'h0234, 1'b0);
        exp_q.push_back('{diff: 16'h1000, bo: 1'b0, z: 1'b0});
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", {31'b0, busy}, 32'd1);
        repeat (3) @(negedge clk);
        check("b2b_not_done_early", {31'b0, done}, 32'd0);
        @(negedge clk);
        check("b2b_done_4_later", {31'b0, done}, 32'd1);

        // Reset sampled at E2 abandons the operation.
        @(negedge clk);
        issue(16'hFFFF, 16'h0001, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_diff", {16'b0, diff}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        wait_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) wait_cnt++;
        end
        check("rst_no_done", wait_cnt, 0);

        run_op(16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0);
        run_op(16'h0010, 16'h0020, 1'b1, 16'hFFEF, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
